// File: rtl/x_srl_delay_line_pkg.sv
// Shared definitions for the addressable shift-register delay line:
// default geometry and an elaboration-time ceil(log2) helper.
package x_srl_delay_line_pkg;

    localparam int SRL_DEF_WIDTH = 8;
    localparam int SRL_DEF_DEPTH = 32;
    localparam int SRL_DEF_AW    = 5;

    // Smallest n with 2**n >= value; used to check that AW can address every stage.
    function automatic int unsigned srl_clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/x_srl_fill_ctr.sv
// Saturating fill counter: counts shifts since reset, stops at DEPTH and flags full.
module x_srl_fill_ctr
    import x_srl_delay_line_pkg::*;
#(
    parameter int DEPTH = SRL_DEF_DEPTH,
    parameter int CW    = SRL_DEF_AW + 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] fill,
    output logic          full
);

    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] FILL_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] fill_r;
    logic [CW-1:0] fill_nxt_s;
    logic          full_r;
    logic          full_nxt_s;

    // next fill count: advance on each shift until saturated
    always_comb begin
        fill_nxt_s = fill_r;
        if (ce && (fill_r != FILL_MAX)) begin
            fill_nxt_s = fill_r + FILL_ONE;
        end else begin
            fill_nxt_s = fill_r;
        end
        full_nxt_s = (fill_nxt_s == FILL_MAX);
    end

    // fill/full state registers; reset wins over a same-cycle shift
    always_ff @(posedge clk_in) begin
        if (rst) begin
            fill_r <= '0;
            full_r <= 1'b0;
        end else begin
            fill_r <= fill_nxt_s;
            full_r <= full_nxt_s;
        end
    end

    assign fill = fill_r;
    assign full = full_r;

endmodule

// File: rtl/x_srl_delay_line.sv
// Addressable WIDTH x DEPTH shift-register delay line with fill tracking,
// per-tap validity and an optional registered tap output.
module x_srl_delay_line
    import x_srl_delay_line_pkg::*;
#(
    parameter int                     WIDTH    = SRL_DEF_WIDTH,
    parameter int                     DEPTH    = SRL_DEF_DEPTH,
    parameter int                     AW       = SRL_DEF_AW,
    parameter logic [WIDTH*DEPTH-1:0] INIT     = '0,
    parameter bit                     RST_DATA = 1'b1,
    parameter bit                     REG_OUT  = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    a,
    output logic [WIDTH-1:0] q,
    output logic             tap_valid,
    output logic [WIDTH-1:0] q_last,
    output logic [AW:0]      fill,
    output logic             full
);

    if ((WIDTH < 1) || (DEPTH < 2) || (AW < int'(srl_clog2(DEPTH)))) begin : g_bad_params
        $error("x_srl_delay_line: illegal WIDTH/DEPTH/AW combination");
    end

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] stage_r [DEPTH];
    logic [WIDTH-1:0] q_s;
    logic             tap_valid_s;
    logic             in_range_s;
    logic [AW:0]      fill_s;
    logic             full_s;

    x_srl_fill_ctr #(
        .DEPTH (DEPTH),
        .CW    (AW + 1)
    ) u_fill_ctr (
        .clk_in (clk_in),
        .rst    (rst),
        .ce     (ce),
        .fill   (fill_s),
        .full   (full_s)
    );

    // storage shift; reset optionally reloads the power-up image
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (RST_DATA) begin
                    stage_r[k] <= INIT[k*WIDTH +: WIDTH];
                end else begin
                    stage_r[k] <= stage_r[k];
                end
            end
        end else if (ce) begin
            stage_r[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // AND-OR tap mux: an out-of-range address selects nothing and yields zero
    always_comb begin
        q_s        = '0;
        in_range_s = ({1'b0, a} < DEPTH_W);
        for (int k = 0; k < DEPTH; k++) begin
            q_s = q_s | (stage_r[k] & {WIDTH{(a == k[AW-1:0])}});
        end
        tap_valid_s = in_range_s && ({1'b0, a} < fill_s);
    end

    if (REG_OUT) begin : g_reg_out
        logic [WIDTH-1:0] q_r;
        logic             tap_valid_r;

        // tap output register, free-running so address changes land one cycle later
        always_ff @(posedge clk_in) begin
            if (rst) begin
                q_r         <= '0;
                tap_valid_r <= 1'b0;
            end else begin
                q_r         <= q_s;
                tap_valid_r <= tap_valid_s;
            end
        end

        assign q         = q_r;
        assign tap_valid = tap_valid_r;
    end else begin : g_comb_out
        assign q         = q_s;
        assign tap_valid = tap_valid_s;
    end

    assign q_last = stage_r[DEPTH-1];
    assign fill   = fill_s;
    assign full   = full_s;

endmodule

// File: tb/tb_x_srl_delay_line.sv
// Directed bench: four delay-line builds share one stimulus stream
// (INIT reload, fill-only reset, registered tap, 20-deep line).
module tb_x_srl_delay_line;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       ce;
    logic [7:0] d;
    logic [4:0] a;

    logic [7:0] qa, qla, qb, qlb, qr, qlr, qs, qls;
    logic       tva, tvb, tvr, tvs;
    logic       fulla, fullb, fullr, fulls;
    logic [5:0] fa, fb, fr, fs;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    x_srl_delay_line #(.WIDTH(8), .DEPTH(32), .AW(5), .INIT({32{8'hA5}}),
                       .RST_DATA(1'b1), .REG_OUT(1'b0)) dut_a (
        .clk_in(clk_in), .rst(rst), .ce(ce), .d(d), .a(a), .q(qa),
        .tap_valid(tva), .q_last(qla), .fill(fa), .full(fulla));

    x_srl_delay_line #(.WIDTH(8), .DEPTH(32), .AW(5), .INIT({32{8'hA5}}),
                       .RST_DATA(1'b0), .REG_OUT(1'b0)) dut_b (
        .clk_in(clk_in), .rst(rst), .ce(ce), .d(d), .a(a), .q(qb),
        .tap_valid(tvb), .q_last(qlb), .fill(fb), .full(fullb));

    x_srl_delay_line #(.WIDTH(8), .DEPTH(32), .AW(5), .INIT({32{8'hA5}}),
                       .RST_DATA(1'b1), .REG_OUT(1'b1)) dut_r (
        .clk_in(clk_in), .rst(rst), .ce(ce), .d(d), .a(a), .q(qr),
        .tap_valid(tvr), .q_last(qlr), .fill(fr), .full(fullr));

    x_srl_delay_line #(.WIDTH(8), .DEPTH(20), .AW(5), .INIT({160{1'b0}}),
                       .RST_DATA(1'b1), .REG_OUT(1'b0)) dut_s (
        .clk_in(clk_in), .rst(rst), .ce(ce), .d(d), .a(a), .q(qs),
        .tap_valid(tvs), .q_last(qls), .fill(fs), .full(fulls));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; d = 8'h00; a = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_fill_a", 16'(fa), 16'h0000);
        chk("rst_full_a", 16'(fulla), 16'h0000);
        chk("rst_tv_a", 16'(tva), 16'h0000);
        chk("rst_q_a", 16'(qa), 16'h00A5);
        chk("rst_q_r", 16'(qr), 16'h0000);
        chk("rst_fill_s", 16'(fs), 16'h0000);

        // five words 01..05
        ce = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            tick();
        end
        ce = 1'b0;
        a = 5'd0; #1;
        chk("t1_q_a0", 16'(qa), 16'h0005);
        chk("t1_tv_a0", 16'(tva), 16'h0001);
        a = 5'd4; #1;
        chk("t1_q_a4", 16'(qa), 16'h0001);
        chk("t1_tv_a4", 16'(tva), 16'h0001);
        a = 5'd5; #1;
        chk("t1_tv_a5", 16'(tva), 16'h0000);
        chk("t1_q_a5", 16'(qa), 16'h00A5);
        chk("t1_fill_a", 16'(fa), 16'h0005);
        chk("t1_fill_s", 16'(fs), 16'h0005);

        // forty more words 00..27 saturate both depths
        ce = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 8'(i);
            tick();
        end
        ce = 1'b0;
        a = 5'd31; #1;
        chk("t2_fill_a", 16'(fa), 16'h0020);
        chk("t2_full_a", 16'(fulla), 16'h0001);
        chk("t2_qlast_a", 16'(qla), 16'h0008);
        chk("t2_q_a31", 16'(qa), 16'h0008);
        chk("t2_fill_s", 16'(fs), 16'h0014);
        chk("t2_full_s", 16'(fulls), 16'h0001);
        chk("t2_qlast_s", 16'(qls), 16'h0014);
        a = 5'd25; #1;
        chk("t6_q_s25", 16'(qs), 16'h0000);
        chk("t6_tv_s25", 16'(tvs), 16'h0000);
        a = 5'd19; #1;
        chk("t6_q_s19", 16'(qs), 16'h0014);
        chk("t6_tv_s19", 16'(tvs), 16'h0001);

        // hold with D toggling
        a = 5'd31;
        for (int i = 0; i < 10; i++) begin
            d = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        chk("t3_q_a31", 16'(qa), 16'h0008);
        chk("t3_qlast_a", 16'(qla), 16'h0008);
        chk("t3_fill_a", 16'(fa), 16'h0020);

        // registered tap: address change shows one edge later
        a = 5'd0;
        tick();
        chk("t5_q_r_a0", 16'(qr), 16'h0027);
        a = 5'd3; #1;
        chk("t5_q_r_pre", 16'(qr), 16'h0027);
        chk("t5_q_a3", 16'(qa), 16'h0024);
        tick();
        chk("t5_q_r_post", 16'(qr), 16'h0024);
        chk("t5_tv_r", 16'(tvr), 16'h0001);

        // reset and shift enable together: reset wins
        d = 8'h55; rst = 1'b1; ce = 1'b1;
        tick();
        rst = 1'b0; ce = 1'b0;
        a = 5'd0; #1;
        chk("t4_q_a0", 16'(qa), 16'h00A5);
        chk("t4_fill_a", 16'(fa), 16'h0000);
        chk("t4_tv_a", 16'(tva), 16'h0000);
        chk("t4_q_b0", 16'(qb), 16'h0027);
        chk("t4_tv_b", 16'(tvb), 16'h0000);
        chk("t4_fill_b", 16'(fb), 16'h0000);
        chk("t4_qlast_b", 16'(qlb), 16'h0008);
        chk("t4_q_r", 16'(qr), 16'h0000);
        a = 5'd31; #1;
        chk("t4_q_a31", 16'(qa), 16'h00A5);
        chk("t4_qlast_a", 16'(qla), 16'h00A5);

        // first shift after reset counts as fill=1
        d = 8'h77; ce = 1'b1;
        tick();
        ce = 1'b0;
        a = 5'd0; #1;
        chk("t4b_q_b0", 16'(qb), 16'h0077);
        chk("t4b_tv_b0", 16'(tvb), 16'h0001);
        chk("t4b_fill_b", 16'(fb), 16'h0001);
        a = 5'd1; #1;
        chk("t4b_q_b1", 16'(qb), 16'h0027);
        chk("t4b_tv_b1", 16'(tvb), 16'h0000);
        chk("t4b_q_a1", 16'(qa), 16'h00A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
